div_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider in the EX stage, beside the ALU.
- Invoked when the decoded ALU control is DIV or DIVU; the ALU drives start/signed_div from that code.
- Produces {remainder, quotient} for the HI/LO write.
- Raises a combinational stall so the pipeline holds EX and earlier stages until the result is ready.

---
 rtl/div_unit_if.sv | 24 ++
 rtl/div_unit.sv | 115 +++++++++++
 tb/tb_div_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX-stage ALU control and the divider.
// The master side drives the operands and control; the slave side returns the result and stall.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               signed_div;
  logic               annul;
  logic [WIDTH-1:0]   opdata1;
  logic [WIDTH-1:0]   opdata2;
  logic [2*WIDTH-1:0] result;
  logic               ready;
  logic               stall;

  modport master (
    output start, signed_div, annul, opdata1, opdata2,
    input  result, ready, stall
  );

  modport slave (
    input  start, signed_div, annul, opdata1, opdata2,
    output result, ready, stall
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider, one quotient bit per cycle.
// Produces {remainder, quotient}; holds the pipeline with a combinational stall.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  div_unit_if.slave   dif
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               op1_neg, op2_neg;
  logic [WIDTH-1:0]   op1_mag, op2_mag;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   step_rem, step_quot;
  logic               accept;

  always_comb begin
    accept  = dif.start && !dif.annul;
    op1_neg = dif.signed_div && dif.opdata1[WIDTH-1];
    op2_neg = dif.signed_div && dif.opdata2[WIDTH-1];
    op1_mag = op1_neg ? (~dif.opdata1 + 1'b1) : dif.opdata1;
    op2_mag = op2_neg ? (~dif.opdata2 + 1'b1) : dif.opdata2;

    // Partial remainder needs one extra bit: after the shift it can reach 2*divisor-1.
    trial     = {rem_q, quot_q[WIDTH-1]} - {1'b0, dvsr_q};
    step_rem  = trial[WIDTH] ? {rem_q[WIDTH-2:0], quot_q[WIDTH-1]} : trial[WIDTH-1:0];
    step_quot = {quot_q[WIDTH-2:0], ~trial[WIDTH]};

    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvsr_d   = dvsr_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          quot_d  = op1_mag;
          dvsr_d  = op2_mag;
          q_neg_d = op1_neg ^ op2_neg;
          r_neg_d = op1_neg;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = (dif.opdata2 == '0) ? S_DIVZERO : S_ON;
        end
      end
      S_ON: begin
        if (dif.annul) begin
          state_d = S_IDLE;
        end else begin
          rem_d  = step_rem;
          quot_d = step_quot;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d  = S_END;
            result_d = {r_neg_q ? (~step_rem + 1'b1) : step_rem,
                        q_neg_q ? (~step_quot + 1'b1) : step_quot};
          end
        end
      end
      S_DIVZERO: begin
        if (dif.annul) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_END;
          result_d = {quot_q, {WIDTH{1'b1}}};
        end
      end
      S_END: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvsr_q   <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvsr_q   <= dvsr_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
    end
  end

  // Stall is low in END so the instruction leaves EX together with the result.
  assign dif.stall  = (state_q == S_IDLE && accept) || state_q == S_ON || state_q == S_DIVZERO;
  assign dif.ready  = (state_q == S_END);
  assign dif.result = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed plus randomized checks of div_unit against an arithmetic reference model.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [63:0] last_exp = '0;

  div_unit_if #(.WIDTH(32)) dif ();
  div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .dif(dif.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Truncating division; remainder takes the dividend's sign. Divide by zero
  // returns the dividend magnitude with an all-ones quotient.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [31:0] mag;
    if (b == 0) begin
      mag = (sgn && a[31]) ? (32'd0 - a) : a;
      return {mag, 32'hFFFF_FFFF};
    end
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    uq = ua / ub;
    ur = ua % ub;
    return {ur[31:0], uq[31:0]};
  endfunction

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit sgn, input string tag);
    logic [63:0] exp;
    int lat;
    bit got;
    exp = ref_div(a, b, sgn);
    lat = (b == 0) ? 2 : 33;
    got = 0;
    dif.opdata1    = a;
    dif.opdata2    = b;
    dif.signed_div = sgn;
    dif.annul      = 1'b0;
    dif.start      = 1'b1;
    #1;
    check({tag, " stall@T"}, 64'(dif.stall), 64'd1);
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge clk); #1;
      dif.opdata1 = $urandom;
      dif.opdata2 = $urandom;
      check({tag, " stall"}, 64'(dif.stall), 64'(i < lat));
      if (dif.ready) begin
        got = 1;
        check({tag, " latency"}, 64'(i), 64'(lat));
        check({tag, " result"}, dif.result, exp);
        dif.start = 1'b0;
      end
    end
    if (!got) check({tag, " timeout"}, 64'd0, 64'd1);
    last_exp = exp;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a, b;
    bit sgn;
    dif.start = 1'b0; dif.signed_div = 1'b0; dif.annul = 1'b0;
    dif.opdata1 = '0; dif.opdata2 = '0;
    #3;
    check("reset result", dif.result, 64'd0);
    check("reset ready", 64'(dif.ready), 64'd0);
    check("reset stall", 64'(dif.stall), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_div(32'd100, 32'd7, 1'b0, "divu 100/7");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "div -7/2");
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, "div 7/-2");
    run_div(32'd5, 32'd0, 1'b0, "divu 5/0");
    run_div(32'd12, 32'd0, 1'b1, "div 12/0");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div ovf");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "divu ovf ops");
    run_div(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "divu big divisor");

    // annul in IDLE must block acceptance
    dif.start = 1'b1; dif.annul = 1'b1; dif.signed_div = 1'b0;
    dif.opdata1 = 32'd40; dif.opdata2 = 32'd4;
    #1;
    check("idle annul stall", 64'(dif.stall), 64'd0);
    @(posedge clk); #1;
    dif.start = 1'b0; dif.annul = 1'b0;
    #1;
    check("idle annul not accepted", 64'(dif.stall), 64'd0);
    @(posedge clk); #1;

    // annul during the 10th ON cycle
    dif.opdata1 = 32'd1000; dif.opdata2 = 32'd3; dif.start = 1'b1;
    for (int i = 1; i <= 10; i++) begin @(posedge clk); #1; end
    dif.annul = 1'b1; dif.start = 1'b0;
    #1;
    check("annul cycle stall", 64'(dif.stall), 64'd1);
    @(posedge clk); #1;
    dif.annul = 1'b0;
    check("annul stall drop", 64'(dif.stall), 64'd0);
    for (int i = 0; i < 30; i++) begin
      check("annul no ready", 64'(dif.ready), 64'd0);
      @(posedge clk); #1;
    end
    check("annul result kept", dif.result, last_exp);
    run_div(32'd9, 32'd3, 1'b0, "divu 9/3 after annul");

    for (int n = 0; n < 12; n++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(1, 15));
        1: b = $urandom;
        2: b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: b = 32'd0;
      endcase
      if (b == 0) sgn = 1'b0;
      run_div(a, b, sgn, $sformatf("rand%0d", n));
    end

    // asynchronous reset mid-divide
    dif.opdata1 = 32'd50; dif.opdata2 = 32'd5; dif.signed_div = 1'b0; dif.start = 1'b1;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    dif.start = 1'b0;
    #1;
    check("pre-reset busy", 64'(dif.stall), 64'd1);
    rst = 1'b1;
    #1;
    check("async rst result", dif.result, 64'd0);
    check("async rst ready", 64'(dif.ready), 64'd0);
    check("async rst idle", 64'(dif.stall), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_div(32'd77, 32'd10, 1'b0, "divu after reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
